// File: rtl/imm_decode_pipe.sv
// Two-stage RV32 immediate decoder, LANES instructions per beat, 2-cycle latency.
// Full valid/ready backpressure; flush and rst kill in-flight beats.
module imm_decode_pipe #(
    parameter int LANES = 1,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*LANES-1:0] in_instr,
    input  logic [LANES-1:0]    in_mask,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*LANES-1:0] out_imm,
    output logic [3*LANES-1:0]  out_fmt,
    output logic [LANES-1:0]    out_illegal,
    output logic [LANES-1:0]    out_mask,
    output logic [TAG_W-1:0]    out_tag,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam logic [2:0] FMT_NONE    = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    logic                s1_valid;
    logic [32*LANES-1:0] s1_instr;
    logic [LANES-1:0]    s1_mask;
    logic [TAG_W-1:0]    s1_tag;

    logic                s2_load;
    logic                s1_load;
    logic                deliver;

    logic [32*LANES-1:0] dec_imm;
    logic [3*LANES-1:0]  dec_fmt;
    logic [LANES-1:0]    dec_ill;
    logic [31:0]         lw;

    logic [CNT_W:0]      pop;
    logic [CNT_W:0]      cnt_sum;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !flush && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    always_comb begin
        dec_imm = '0;
        dec_fmt = '0;
        dec_ill = '0;
        lw      = '0;
        for (int k = 0; k < LANES; k++) begin
            lw = s1_instr[32*k +: 32];
            if (s1_mask[k]) begin
                case (lw[6:0])
                    7'b0110011: dec_fmt[3*k +: 3] = FMT_NONE;
                    7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                        dec_fmt[3*k +: 3]  = FMT_I;
                        dec_imm[32*k +: 32] = {{20{lw[31]}}, lw[31:20]};
                    end
                    7'b0100011: begin
                        dec_fmt[3*k +: 3]  = FMT_S;
                        dec_imm[32*k +: 32] = {{20{lw[31]}}, lw[31:25], lw[11:7]};
                    end
                    7'b1100011: begin
                        dec_fmt[3*k +: 3]  = FMT_B;
                        dec_imm[32*k +: 32] = {{19{lw[31]}}, lw[31], lw[7], lw[30:25], lw[11:8], 1'b0};
                    end
                    7'b0110111, 7'b0010111: begin
                        dec_fmt[3*k +: 3]  = FMT_U;
                        dec_imm[32*k +: 32] = {lw[31:12], 12'b0};
                    end
                    7'b1101111: begin
                        dec_fmt[3*k +: 3]  = FMT_J;
                        dec_imm[32*k +: 32] = {{11{lw[31]}}, lw[31], lw[19:12], lw[20], lw[30:21], 1'b0};
                    end
                    default: begin
                        dec_fmt[3*k +: 3] = FMT_ILLEGAL;
                        dec_ill[k]        = 1'b1;
                    end
                endcase
            end
        end
    end

    // cnt_sum has one spare bit so an overflow is visible before it would wrap
    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + (CNT_W+1)'(out_illegal[k]);
        end
        cnt_sum = {1'b0, illegal_cnt} + pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_mask  <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_instr <= in_instr;
            s1_mask  <= in_mask;
            s1_tag   <= in_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= '0;
            out_mask    <= '0;
            out_tag     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_ill;
            out_mask    <= s1_mask;
            out_tag     <= s1_tag;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (deliver) begin
            illegal_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Randomized scoreboard bench for imm_decode_pipe (2 lanes, 6-bit counter to reach saturation).
module tb_imm_decode_pipe;

    localparam int CNT_MAX = 63;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_instr = '0;
    logic [1:0]  in_mask = '0;
    logic [15:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_imm;
    logic [5:0]  out_fmt;
    logic [1:0]  out_illegal;
    logic [1:0]  out_mask;
    logic [15:0] out_tag;
    logic [5:0]  illegal_cnt;

    imm_decode_pipe #(.LANES(2), .TAG_W(16), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_mask(in_mask), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_mask(out_mask),
        .out_tag(out_tag), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [5:0]  fmt;
        logic [1:0]  ill;
        logic [1:0]  mask;
        logic [15:0] tag;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cnt_model = 0;
    bit    rnd_rdy = 1'b0;
    bit    fix_rdy = 1'b1;

    function automatic int opfmt(input logic [6:0] op);
        if (op == 7'h33) return 0;
        if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) return 1;
        if (op == 7'h23) return 2;
        if (op == 7'h63) return 3;
        if (op inside {7'h37, 7'h17}) return 4;
        if (op == 7'h6F) return 5;
        return 7;
    endfunction

    // Immediates rebuilt arithmetically: signed shifts supply the sign, masks pick the fields.
    function automatic beat_t model(input logic [63:0] ins, input logic [1:0] m, input logic [15:0] t);
        beat_t              b;
        logic [31:0]        w;
        logic signed [31:0] sw;
        logic [31:0]        sgn;
        logic [31:0]        hi20;
        logic [31:0]        hi25;
        logic [31:0]        v;
        int                 f;
        b.imm = '0; b.fmt = '0; b.ill = '0; b.mask = m; b.tag = t;
        for (int k = 0; k < 2; k++) begin
            if (m[k]) begin
                w    = ins[32*k +: 32];
                sw   = w;
                sgn  = sw >>> 31;
                hi20 = sw >>> 20;
                hi25 = sw >>> 25;
                f    = opfmt(w[6:0]);
                case (f)
                    1: v = hi20;
                    2: v = (hi25 << 5) | ((w >> 7) & 32'h1F);
                    3: v = (sgn << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
                           | (((w >> 8) & 32'hF) << 1);
                    4: v = w & 32'hFFFFF000;
                    5: v = (sgn << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 32'h1) << 11)
                           | (((w >> 21) & 32'h3FF) << 1);
                    default: v = 32'h0;
                endcase
                b.imm[32*k +: 32] = v;
                b.fmt[3*k +: 3]   = 3'(f);
                b.ill[k]          = (f == 7);
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom;
        if ($urandom_range(0, 9) < 7) r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
    end

    // Monitor: pops the scoreboard on every delivery and checks hold-stability and the counter.
    logic        prev_hold = 1'b0;
    logic        prev_flush = 1'b0;
    logic [63:0] p_imm;
    logic [5:0]  p_fmt;
    logic [1:0]  p_ill;
    logic [15:0] p_tag;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && !prev_flush) begin
                checks++;
                if (out_valid !== 1'b1 || out_imm !== p_imm || out_fmt !== p_fmt
                    || out_illegal !== p_ill || out_tag !== p_tag) begin
                    errors++;
                    $display("FAIL hold_stable: got vld=%b imm=%h tag=%h, need vld=1 imm=%h tag=%h",
                             out_valid, out_imm, out_tag, p_imm, p_tag);
                end
            end
            checks++;
            if (illegal_cnt !== 6'(cnt_model)) begin
                errors++;
                $display("FAIL illegal_cnt: got %0d, need %0d", illegal_cnt, cnt_model);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got tag=%h imm=%h, need no beat", out_tag, out_imm);
                end else begin
                    e = exp_q.pop_front();
                    if (out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill
                        || out_mask !== e.mask || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL beat: got imm=%h fmt=%h ill=%b mask=%b tag=%h, need imm=%h fmt=%h ill=%b mask=%b tag=%h",
                                 out_imm, out_fmt, out_illegal, out_mask, out_tag,
                                 e.imm, e.fmt, e.ill, e.mask, e.tag);
                    end
                    cnt_model = cnt_model + int'(e.ill[0]) + int'(e.ill[1]);
                    if (cnt_model > CNT_MAX) cnt_model = CNT_MAX;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_flush = flush;
            p_imm = out_imm; p_fmt = out_fmt; p_ill = out_illegal; p_tag = out_tag;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ins, input logic [1:0] m, input logic [15:0] t);
        bit ok;
        ok = 1'b0;
        in_instr = ins; in_mask = m; in_tag = t; in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(ins, m, t));
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        fix_rdy = 1'b1;
        rnd_rdy = 1'b0;
        for (int c = 0; c < 100 && (exp_q.size() != 0 || out_valid); c++) tick();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] seq_ins [3];
    logic [31:0] seq_imm [3];
    logic [2:0]  seq_fmt [3];
    logic [15:0] tg;
    int          acc;

    initial begin
        seq_ins = '{32'hFE000CE3, 32'hFFDFF06F, 32'h123452B7};
        seq_imm = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000};
        seq_fmt = '{3'd3, 3'd5, 3'd4};

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // addi x1,x0,-1 in lane 0: exactly two edges from accept to out_valid
        send({32'h0, 32'hFFF00093}, 2'b01, 16'h0034);
        check("lat_edge1", 64'(out_valid), 64'd0);
        tick();
        check("lat_edge2", 64'(out_valid), 64'd1);
        check("addi_imm", 64'(out_imm[31:0]), 64'hFFFFFFFF);
        check("addi_fmt", 64'(out_fmt[2:0]), 64'd1);
        check("addi_ill", 64'(out_illegal[0]), 64'd0);
        drain();

        // branch/jal/lui back-to-back must emerge on consecutive cycles
        fork
            begin
                for (int j = 0; j < 3; j++) send({$urandom, seq_ins[j]}, 2'b01, 16'(j));
            end
            begin
                for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
                for (int j = 0; j < 3; j++) begin
                    check("b2b_valid", 64'(out_valid), 64'd1);
                    check("b2b_imm", 64'(out_imm[31:0]), 64'(seq_imm[j]));
                    check("b2b_fmt", 64'(out_fmt[2:0]), 64'(seq_fmt[j]));
                    @(negedge clk);
                end
            end
        join
        drain();

        // backpressure: three beats offered over four stalled cycles, only two fit
        fix_rdy = 1'b0;
        tick(); tick();
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_instr = {32'h00000033, seq_ins[acc]}; in_mask = 2'b11; in_tag = 16'(16'h100 + acc);
            @(negedge clk);
            if (in_ready && acc < 3) begin
                exp_q.push_back(model(in_instr, in_mask, in_tag));
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        fix_rdy = 1'b1;
        send({32'h00000033, seq_ins[2]}, 2'b11, 16'h0102);
        drain();

        // illegal lane 0 plus R-type lane 1
        send({32'h00000033, 32'h00000000}, 2'b11, 16'h0037);
        drain();

        // randomized traffic with random consumer stalls
        rnd_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            tg = 16'($urandom);
            send({rand_instr(), rand_instr()}, 2'($urandom), tg);
            if ($urandom_range(0, 4) == 0) tick();
        end
        drain();

        // push the counter into saturation
        for (int n = 0; n < 40; n++) send(64'h0, 2'b11, 16'(n));
        drain();
        check("cnt_saturated", 64'(illegal_cnt), 64'(CNT_MAX));
        send(64'h0, 2'b11, 16'hBEEF);
        drain();
        check("cnt_stays_max", 64'(illegal_cnt), 64'(CNT_MAX));

        // flush with both stages occupied
        fix_rdy = 1'b0;
        tick();
        send({32'h0, 32'hFFF00093}, 2'b01, 16'hF1);
        send({32'h0, 32'hFFF00093}, 2'b01, 16'hF2);
        check("flush_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        fix_rdy = 1'b1;
        tick(); tick();
        check("flush_no_delivery", 64'(out_valid), 64'd0);

        // a beat offered during flush is refused
        in_valid = 1'b1; in_instr = 64'h13; in_mask = 2'b01; in_tag = 16'hF3;
        flush = 1'b1;
        #2;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick();
        check("flush_beat_dropped", 64'(out_valid), 64'd0);
        check("flush_cnt_kept", 64'(illegal_cnt), 64'(CNT_MAX));

        // asynchronous reset mid-stream with data in flight
        fix_rdy = 1'b0;
        tick();
        send({32'hFFDFF06F, 32'hFE000CE3}, 2'b11, 16'hAA);
        send({32'hFFDFF06F, 32'hFE000CE3}, 2'b11, 16'hAB);
        #1;
        rst = 1'b1;
        exp_q.delete();
        cnt_model = 0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_imm", out_imm, 64'd0);
        check("arst_tag", 64'(out_tag), 64'd0);
        check("arst_cnt", 64'(illegal_cnt), 64'd0);
        tick();
        rst = 1'b0;
        fix_rdy = 1'b1;
        tick();
        check("post_arst_ready", 64'(in_ready), 64'd1);
        tick(); tick();
        check("post_arst_empty", 64'(out_valid), 64'd0);
        send({32'h00000033, 32'hFFF00093}, 2'b11, 16'h0042);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
